cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 31 +++
 rtl/cpu_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the accumulator-CPU sequencer and its datapath/memory.
// Sequencer strobes are combinational from state, opcode and carry, gated by ce.
interface cpu_sequencer_if;
    logic       ce;
    logic [1:0] opcode;
    logic       carry;
    logic       enable_PC;
    logic       clear_PC;
    logic       load_PC;
    logic       load_IR;
    logic       sel_adr;
    logic       mem_ce;
    logic       mem_we;
    logic       load_ACC;
    logic       sel_UAL;
    logic       load_carry;
    logic       clear_carry;
    logic [2:0] state_dbg;

    modport master (
        output ce, opcode, carry,
        input  enable_PC, clear_PC, load_PC, load_IR, sel_adr, mem_ce, mem_we,
               load_ACC, sel_UAL, load_carry, clear_carry, state_dbg
    );

    modport slave (
        input  ce, opcode, carry,
        output enable_PC, clear_PC, load_PC, load_IR, sel_adr, mem_ce, mem_we,
               load_ACC, sel_UAL, load_carry, clear_carry, state_dbg
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXE, 3 ce-cycles per ALU/STA op, 2 per JCC.
// ce=0 freezes the state and forces every strobe low; rst forces INIT with strobes low.
module cpu_sequencer (
    input  logic             clk,
    input  logic             rst,
    cpu_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXE_UAL = 3'd3,
        EXE_STA = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic en_pc, clr_pc, ld_pc, ld_ir, sel_adr, mem_ce, mem_we;
    logic ld_acc, sel_ual, ld_carry, clr_carry;
    logic run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_pc     = 1'b0;
        clr_pc    = 1'b0;
        ld_pc     = 1'b0;
        ld_ir     = 1'b0;
        sel_adr   = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        ld_acc    = 1'b0;
        sel_ual   = 1'b0;
        ld_carry  = 1'b0;
        clr_carry = 1'b0;
        case (state_q)
            INIT: begin
                en_pc     = 1'b1;
                clr_pc    = 1'b1;
                clr_carry = 1'b1;
                state_d   = FETCH;
            end
            FETCH: begin
                mem_ce  = 1'b1;
                ld_ir   = 1'b1;
                en_pc   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (bus.opcode)
                    2'b00, 2'b01: begin
                        sel_adr = 1'b1;
                        mem_ce  = 1'b1;
                        state_d = EXE_UAL;
                    end
                    2'b10: begin
                        sel_adr = 1'b1;
                        state_d = EXE_STA;
                    end
                    default: begin
                        // JCC jumps on carry clear; a set carry is consumed instead
                        ld_pc     = ~bus.carry;
                        clr_carry = bus.carry;
                        state_d   = FETCH;
                    end
                endcase
            end
            EXE_UAL: begin
                sel_adr  = 1'b1;
                mem_ce   = 1'b1;
                ld_acc   = 1'b1;
                sel_ual  = bus.opcode[0];
                ld_carry = bus.opcode[0];
                state_d  = FETCH;
            end
            EXE_STA: begin
                sel_adr = 1'b1;
                mem_ce  = 1'b1;
                mem_we  = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        if (!bus.ce) begin
            state_d = state_q;
        end
    end

    // Reset gates the strobes combinationally so an aborted instruction emits nothing
    assign run = bus.ce & ~rst;

    assign bus.enable_PC   = run & en_pc;
    assign bus.clear_PC    = run & clr_pc;
    assign bus.load_PC     = run & ld_pc;
    assign bus.load_IR     = run & ld_ir;
    assign bus.sel_adr     = run & sel_adr;
    assign bus.mem_ce      = run & mem_ce;
    assign bus.mem_we      = run & mem_we;
    assign bus.load_ACC    = run & ld_acc;
    assign bus.sel_UAL     = run & sel_ual;
    assign bus.load_carry  = run & ld_carry;
    assign bus.clear_carry = run & clr_carry;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: hand-computed state and strobe vectors.
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe word order: enable_PC clear_PC load_PC load_IR sel_adr mem_ce mem_we
    //                    load_ACC sel_UAL load_carry clear_carry
    localparam logic [10:0] S_ZERO    = 11'b00000000000;
    localparam logic [10:0] S_INIT    = 11'b11000000001;
    localparam logic [10:0] S_FETCH   = 11'b10010100000;
    localparam logic [10:0] S_DEC_UAL = 11'b00001100000;
    localparam logic [10:0] S_DEC_STA = 11'b00001000000;
    localparam logic [10:0] S_DEC_JT  = 11'b00100000000;
    localparam logic [10:0] S_DEC_JN  = 11'b00000000001;
    localparam logic [10:0] S_EXE_ADD = 11'b00001101110;
    localparam logic [10:0] S_EXE_NOR = 11'b00001101000;
    localparam logic [10:0] S_EXE_STA = 11'b00001110000;

    function automatic logic [10:0] strobes();
        return {bus.enable_PC, bus.clear_PC, bus.load_PC, bus.load_IR, bus.sel_adr,
                bus.mem_ce, bus.mem_we, bus.load_ACC, bus.sel_UAL, bus.load_carry,
                bus.clear_carry};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st, input logic [10:0] stb);
        check({tag, ".state"}, {13'd0, bus.state_dbg}, {13'd0, st});
        check({tag, ".strb"},  {5'd0, strobes()},      {5'd0, stb});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        bus.ce     = 1'b1;
        bus.opcode = 2'b00;
        bus.carry  = 1'b0;

        #3;
        expect_st("rst_pre_edge", 3'd0, S_ZERO);
        step();
        expect_st("rst_held", 3'd0, S_ZERO);
        #1 rst = 1'b0;
        #1;
        expect_st("init", 3'd0, S_INIT);

        // ADD: FETCH, DECODE, EXE_UAL, then FETCH
        bus.opcode = 2'b01;
        step(); expect_st("add_fetch",  3'd1, S_FETCH);
        step(); expect_st("add_decode", 3'd2, S_DEC_UAL);
        step(); expect_st("add_exe",    3'd3, S_EXE_ADD);
        step(); expect_st("add_next",   3'd1, S_FETCH);

        bus.opcode = 2'b00;
        step(); expect_st("nor_decode", 3'd2, S_DEC_UAL);
        step(); expect_st("nor_exe",    3'd3, S_EXE_NOR);
        step(); expect_st("nor_next",   3'd1, S_FETCH);

        bus.opcode = 2'b10;
        step(); expect_st("sta_decode", 3'd2, S_DEC_STA);
        step(); expect_st("sta_exe",    3'd4, S_EXE_STA);
        step(); expect_st("sta_next",   3'd1, S_FETCH);

        // JCC taken then not taken, two cycles each
        bus.opcode = 2'b11;
        bus.carry  = 1'b0;
        step(); expect_st("jcc_t_decode", 3'd2, S_DEC_JT);
        step(); expect_st("jcc_t_next",   3'd1, S_FETCH);
        bus.carry = 1'b1;
        step(); expect_st("jcc_n_decode", 3'd2, S_DEC_JN);
        step(); expect_st("jcc_n_next",   3'd1, S_FETCH);
        bus.carry = 1'b0;

        // Clock-enable stall in DECODE
        bus.opcode = 2'b01;
        step(); expect_st("ce_decode", 3'd2, S_DEC_UAL);
        bus.ce = 1'b0;
        #1;
        expect_st("ce_off_now", 3'd2, S_ZERO);
        for (int i = 0; i < 5; i++) begin
            step(); expect_st($sformatf("ce_hold%0d", i), 3'd2, S_ZERO);
        end
        bus.ce = 1'b1;
        #1;
        expect_st("ce_resume", 3'd2, S_DEC_UAL);
        step(); expect_st("ce_exe", 3'd3, S_EXE_ADD);

        // Asynchronous reset aborts EXE_UAL
        #1 rst = 1'b1;
        #1;
        expect_st("rst_async", 3'd0, S_ZERO);
        step(); expect_st("rst_async_edge", 3'd0, S_ZERO);
        rst = 1'b0;
        #1;
        expect_st("rst_release", 3'd0, S_INIT);
        step(); expect_st("rst_fetch", 3'd1, S_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
